// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: multi-stage RV32 forwarding selects plus load-use / memory-wait stall and branch flush sequencing
// Ports: rs1/rs2/use_rs1/use_rs2 describe the consumer; stg_rd/stg_rf_wr/stg_is_load describe producer stages
// 1..NUM_STAGES (stage 1 nearest, in the low bits); br_taken and mem_ready drive the FSM; fwd_sel1/fwd_sel2
// give 0 = register file or k = stage k; stall/flush steer the front end.
// Optional HAZARD_PERF_EN adds stall_cnt (cycles stalled) and flush_cnt (flush rising edges), both saturating.
module hazard_fwd_unit #(
  parameter int NUM_STAGES = 2,
  parameter int LOAD_STALL = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int SELW = $clog2(NUM_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic                    use_rs1,
  input  logic                    use_rs2,
  input  logic [5*NUM_STAGES-1:0] stg_rd,
  input  logic [NUM_STAGES-1:0]   stg_rf_wr,
  input  logic [NUM_STAGES-1:0]   stg_is_load,
  input  logic                    br_taken,
  input  logic                    mem_ready,
  output logic [SELW-1:0]         fwd_sel1,
  output logic [SELW-1:0]         fwd_sel2,
  output logic                    stall,
  output logic                    flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;
  localparam logic [2:0] LS_M1 = 3'(LOAD_STALL - 1);
  localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
  // single-cycle configurations never leave IDLE
  localparam state_t BR_NXT = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
  localparam state_t LU_NXT = (LOAD_STALL > 1) ? STALL : IDLE;
  state_t st, nxt;
  logic [2:0] cnt, cnt_n;
  logic [SELW-1:0] sel1_c, sel2_c;
  logic stall_c, flush_c, lu;
  logic unused_ld;
  assign unused_ld = ^stg_is_load;
  // walk far to near so the nearest matching producer overwrites
  always_comb begin
    sel1_c = '0;
    sel2_c = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (stg_rf_wr[k-1] && stg_rd[5*k-1 -: 5] == rs1 && rs1 != 5'd0 && use_rs1) sel1_c = SELW'(k);
      if (stg_rf_wr[k-1] && stg_rd[5*k-1 -: 5] == rs2 && rs2 != 5'd0 && use_rs2) sel2_c = SELW'(k);
    end
  end
  assign lu = stg_is_load[0] && stg_rf_wr[0] && stg_rd[4:0] != 5'd0 &&
              ((use_rs1 && rs1 == stg_rd[4:0]) || (use_rs2 && rs2 == stg_rd[4:0]));
  always_comb begin
    nxt = st;
    cnt_n = cnt;
    stall_c = 1'b0;
    flush_c = 1'b0;
    if (st == FLUSH) begin
      flush_c = 1'b1;
      cnt_n = br_taken ? FC_M1 : 3'(cnt - 3'd1);
      nxt = (!br_taken && cnt == 3'd1) ? IDLE : FLUSH;
    end else if (br_taken) begin
      flush_c = 1'b1;
      nxt = BR_NXT;
      cnt_n = FC_M1;
    end else if (st == STALL) begin
      stall_c = 1'b1;
      // memory wait freezes the load-use countdown
      cnt_n = mem_ready ? 3'(cnt - 3'd1) : cnt;
      nxt = (mem_ready && cnt == 3'd1) ? IDLE : STALL;
    end else if (lu) begin
      stall_c = 1'b1;
      nxt = LU_NXT;
      cnt_n = LS_M1;
    end else begin
      stall_c = ~mem_ready;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
    end else begin
      st <= nxt;
      cnt <= cnt_n;
    end
  end
  // outputs are gated so they drop the instant reset asserts, even mid-sequence
  assign fwd_sel1 = rst_n ? sel1_c : '0;
  assign fwd_sel2 = rst_n ? sel2_c : '0;
  assign stall = rst_n & stall_c;
  assign flush = rst_n & flush_c;
`ifdef HAZARD_PERF_EN
  logic flush_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (flush && !flush_q && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scoreboard bench for hazard_fwd_unit (NUM_STAGES=2, LOAD_STALL=2, FLUSH_CYCLES=3)
module tb_hazard_fwd_unit;
  localparam int NS = 2;
  localparam int SW = $clog2(NS + 1);
  localparam logic [9:0] RD55 = {5'd5, 5'd5};
  localparam logic [9:0] RD07 = {5'd0, 5'd7};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0;
  logic use_rs1 = 1'b0, use_rs2 = 1'b0, br_taken = 1'b0, mem_ready = 1'b1;
  logic [5*NS-1:0] stg_rd = '0;
  logic [NS-1:0] stg_rf_wr = '0, stg_is_load = '0;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic stall, flush;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  hazard_fwd_unit #(.NUM_STAGES(NS), .LOAD_STALL(2), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .stg_rd(stg_rd), .stg_rf_wr(stg_rf_wr), .stg_is_load(stg_is_load), .br_taken(br_taken),
    .mem_ready(mem_ready), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall(stall), .flush(flush)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int id;
    logic [SW-1:0] s1;
    logic [SW-1:0] s2;
    logic st;
    logic fl;
    bit cp;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;
  exp_t q[$];
  int total = 0, passed = 0, vid = 0;
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", nm, id, act, exp);
  endtask
  task automatic drv(input logic rn, input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [9:0] rd, input logic [1:0] wr, input logic [1:0] ld, input logic br, input logic mr,
                     input logic [SW-1:0] e1, input logic [SW-1:0] e2, input logic est, input logic efl,
                     input bit cp = 1'b0, input logic [31:0] eps = 0, input logic [31:0] epf = 0);
    @(posedge clk);
    #1;
    rst_n = rn; rs1 = r1; use_rs1 = u1; rs2 = r2; use_rs2 = u2;
    stg_rd = rd; stg_rf_wr = wr; stg_is_load = ld; br_taken = br; mem_ready = mr;
    vid++;
    q.push_back('{vid, e1, e2, est, efl, cp, eps, epf});
  endtask
  task automatic quiet(input logic br, input logic mr, input logic est, input logic efl, input logic rn = 1'b1);
    drv(rn, 5'd0, 1'b0, 5'd0, 1'b0, 10'd0, 2'b00, 2'b00, br, mr, 2'd0, 2'd0, est, efl, !rn, 0, 0);
  endtask
  // load in stage 1 writing x7, consumer reads x7 as rs2
  task automatic lu_v(input logic br, input logic mr, input logic est, input logic efl);
    drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, RD07, 2'b01, 2'b01, br, mr, 2'd0, 2'd1, est, efl);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fwd_sel1", e.id, 32'(fwd_sel1), 32'(e.s1));
      chk("fwd_sel2", e.id, 32'(fwd_sel2), 32'(e.s2));
      chk("stall", e.id, 32'(stall), 32'(e.st));
      chk("flush", e.id, 32'(flush), 32'(e.fl));
`ifdef HAZARD_PERF_EN
      if (e.cp) begin
        chk("stall_cnt", e.id, stall_cnt, e.ps);
        chk("flush_cnt", e.id, flush_cnt, e.pf);
      end
`endif
    end
  end
  initial begin
    // reset masks a live forwarding match
    drv(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, RD55, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 0);
    // forwarding priority
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, RD55, 2'b11, 2'b00, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 1'b0);
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, RD55, 2'b10, 2'b00, 1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0);
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, RD55, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    drv(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, RD55, 2'b11, 2'b00, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, RD55, 2'b11, 2'b00, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
    // load to x0 never stalls
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 10'd0, 2'b01, 2'b01, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    // load-use: two stall cycles, then load result forwarded without stall
    lu_v(1'b0, 1'b1, 1'b1, 1'b0);
    lu_v(1'b0, 1'b1, 1'b1, 1'b0);
    drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, RD07, 2'b01, 2'b00, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2, 0);
    // load whose result is not used
    drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b0, RD07, 2'b01, 2'b01, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
    // branch: three flush cycles, load-use ignored while flushing
    quiet(1'b1, 1'b1, 1'b0, 1'b1);
    lu_v(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // second branch in cycle 2 extends flush to cycle 4; memory wait ignored in FLUSH
    quiet(1'b1, 1'b1, 1'b0, 1'b1);
    quiet(1'b1, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b0, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // branch in second stall cycle aborts the stall
    lu_v(1'b0, 1'b1, 1'b1, 1'b0);
    lu_v(1'b1, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // branch beats load-use in IDLE
    lu_v(1'b1, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // memory wait in IDLE
    for (int i = 0; i < 4; i++) quiet(1'b0, 1'b0, 1'b1, 1'b0);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // memory wait freezes STALL at cnt = 1
    lu_v(1'b0, 1'b1, 1'b1, 1'b0);
    lu_v(1'b0, 1'b0, 1'b1, 1'b0);
    lu_v(1'b0, 1'b0, 1'b1, 1'b0);
    lu_v(1'b0, 1'b1, 1'b1, 1'b0);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    // reset asserted mid-FLUSH drops flush before the next clock edge, then FSM is back in IDLE
    quiet(1'b1, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b1);
    quiet(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    quiet(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard/forwarding controller for deeper RV32 pipelines; successor to the single-stage rd-compare forwarder.
- Compares the decode/execute source registers against NUM_STAGES downstream producers and emits per-operand forwarding selects, nearest producer first.
- Sequences multi-cycle load-use stalls, memory-wait stalls and multi-cycle branch flushes through an internal FSM.

Parameters:
- NUM_STAGES, 2, number of downstream producer stages; stage 1 is nearest. Legal range 1..7.
- LOAD_STALL, 1, stall cycles inserted on a load-use hazard against stage 1. Legal range 1..7.
- FLUSH_CYCLES, 1, cycles flush is held after a taken branch. Legal range 1..7.
- SELW, $clog2(NUM_STAGES+1), width of each forwarding select.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs1  in  5  source register 1 of the consuming instruction
- rs2  in  5  source register 2 of the consuming instruction
- use_rs1  in  1  consuming instruction reads rs1
- use_rs2  in  1  consuming instruction reads rs2
- stg_rd  in  5*NUM_STAGES  destination register per stage; stage k occupies bits [5k-1:5k-5]
- stg_rf_wr  in  NUM_STAGES  stage k writes the register file
- stg_is_load  in  NUM_STAGES  stage k holds a load
- br_taken  in  1  taken branch or jump resolved this cycle
- mem_ready  in  1  data memory can complete this cycle
- fwd_sel1  out  SELW  forwarding source for op1: 0 = register file, k = stage k
- fwd_sel2  out  SELW  forwarding source for op2
- stall  out  1  hold PC and front-end registers; insert a bubble
- flush  out  1  squash front-end instructions

Behaviour:
- Clock and reset:
  - One clock domain.
  - The asynchronous reset is active-low.
  - While rst_n = 0, all outputs are 0, the FSM is in IDLE and all counters are 0.
- Forwarding (combinational):
  - fwd_selN = smallest k with stg_rf_wr[k] & (stg_rd[k] == rsN) & (rsN != 0) & use_rsN; otherwise 0.
  - Nearest stage always wins.
  - Forwarding is computed in every state, including STALL and FLUSH.
- Load-use detection (combinational):
  - lu = stg_is_load[1] & stg_rf_wr[1] & (stg_rd[1] != 0), and stg_rd[1] matches a used, nonzero rs1 or rs2.
- FSM states: IDLE, STALL, FLUSH. cnt is a 3-bit down-counter.
- IDLE:
  - br_taken → flush = 1 this cycle. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1.
  - Otherwise, lu → stall = 1 this cycle. If LOAD_STALL > 1, go to STALL with cnt = LOAD_STALL-1.
  - Otherwise, stall = ~mem_ready.
- STALL:
  - stall = 1; cnt decrements each cycle; return to IDLE after the cycle in which cnt = 1.
  - br_taken in STALL aborts the stall: flush = 1, stall = 0, then FLUSH handling as from IDLE.
- FLUSH:
  - flush = 1 and stall = 0; cnt decrements; return to IDLE after cnt = 1.
  - br_taken in FLUSH reloads cnt = FLUSH_CYCLES-1.
  - lu is ignored in FLUSH (the consumer is squashed).
- Memory wait:
  - mem_ready = 0 in IDLE or STALL forces stall = 1, and the STALL counter freezes.
  - In FLUSH, mem_ready is ignored for stall; the flush counter still runs.
- Priority: flush > load-use stall > memory stall.
- Mutual exclusion: stall and flush are never both 1.
- Reset mid-operation: asserting rst_n = 0 in STALL or FLUSH drops stall and flush immediately, asynchronously.
- Degenerate parameters: LOAD_STALL = 1 and FLUSH_CYCLES = 1 never leave IDLE. This reproduces single-cycle behaviour.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, add two outputs:
  - stall_cnt, 32 bits: counts cycles with stall = 1.
  - flush_cnt, 32 bits: counts rising edges of flush, i.e. branch events.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority:
  - rs1 = 5, use_rs1 = 1, stg_rd = {5, 5}, stg_rf_wr = 2'b11, no loads → fwd_sel1 = 1.
  - Clear stg_rf_wr[1] → fwd_sel1 = 2.
  - rs1 = 0 → fwd_sel1 = 0.
- Load-use, LOAD_STALL = 2:
  - stg_is_load[1] = 1, stg_rd[1] = 7, rs2 = 7, use_rs2 = 1 → stall = 1 for exactly 2 cycles, then 0.
  - fwd_sel2 = 1 throughout.
- Branch, FLUSH_CYCLES = 3:
  - br_taken pulse 1 cycle → flush = 1 for 3 cycles, stall = 0.
  - Second br_taken in cycle 2 → flush extends to cycle 4.
- Branch during load stall:
  - br_taken in the 2nd STALL cycle → stall drops that cycle, flush = 1, FSM in FLUSH.
- Memory wait:
  - mem_ready = 0 for 4 cycles in IDLE → stall = 1 for those 4 cycles.
  - mem_ready = 0 during STALL with cnt = 1 → stall extends until mem_ready = 1, plus 1 cycle.
- Reset and perf counters:
  - Assert rst_n = 0 mid-FLUSH → flush = 0 asynchronously, before the next clk edge.
  - With HAZARD_PERF_EN, after scenario 2: stall_cnt = 2, flush_cnt = 0.
